// File: rtl/u712_chip_ram_arbiter_pkg.sv
// Shared types and default timing constants for the U712 chip RAM arbiter.
package u712_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DMA  = 2'd1,
    ST_CPU  = 2'd2,
    ST_REF  = 2'd3
  } arb_state_e;

  localparam int unsigned REF_INTERVAL_DEF   = 624;
  localparam int unsigned REF_PEND_MAX_DEF   = 7;
  localparam int unsigned REF_URGENT_DEF     = 4;
  localparam int unsigned CPU_LATE_LIMIT_DEF = 6;

  localparam int unsigned PHASE_W = 5;
  localparam int unsigned PEND_W  = 3;

endpackage

// File: rtl/u712_chip_ram_arbiter_if.sv
// Bus-side signals of the chip RAM arbiter: Amiga phase clocks, requests and grants.
interface u712_chip_ram_arbiter_if;
  import u712_pkg::*;

  logic               i_C1;
  logic               i_C3;
  logic               i_DBR_SYNC;
  logic               i_CPU_REQ;
  logic               i_CYC_DONE;
  logic               o_DMA_GNT;
  logic               o_CPU_GNT;
  logic               o_REF_GNT;
  logic               o_SLOT_START;
  logic [PHASE_W-1:0] o_SLOT_PHASE;
  logic [PEND_W-1:0]  o_REF_PEND;
  logic               o_DMA_MISS;

  modport slave (
    input  i_C1, i_C3, i_DBR_SYNC, i_CPU_REQ, i_CYC_DONE,
    output o_DMA_GNT, o_CPU_GNT, o_REF_GNT, o_SLOT_START,
           o_SLOT_PHASE, o_REF_PEND, o_DMA_MISS
  );

  modport master (
    output i_C1, i_C3, i_DBR_SYNC, i_CPU_REQ, i_CYC_DONE,
    input  o_DMA_GNT, o_CPU_GNT, o_REF_GNT, o_SLOT_START,
           o_SLOT_PHASE, o_REF_PEND, o_DMA_MISS
  );

endinterface

// File: rtl/u712_chip_ram_arbiter_refresh.sv
// Refresh interval timer and saturating pending-refresh counter.
module u712_refresh_timer
  import u712_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = REF_INTERVAL_DEF,
  parameter int unsigned REF_PEND_MAX = REF_PEND_MAX_DEF
) (
  input  logic              i_CLK80,
  input  logic              i_RESETn,
  input  logic              i_REF_TAKE,
  output logic [PEND_W-1:0] o_REF_PEND
);

  localparam int unsigned CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REF_INTERVAL - 1);
  localparam logic [PEND_W-1:0] PEND_SAT = PEND_W'(REF_PEND_MAX);

  logic [CNT_W-1:0]  r_cnt;
  logic [PEND_W-1:0] r_pend;
  logic              w_tick;

  assign w_tick = (r_cnt == CNT_LAST);

  // A tick coinciding with a take cancels out; a tick at saturation is lost.
  always_ff @(posedge i_CLK80) begin
    if (!i_RESETn) begin
      r_cnt  <= '0;
      r_pend <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick && !i_REF_TAKE) begin
        if (r_pend != PEND_SAT) r_pend <= r_pend + 1'b1;
      end else if (i_REF_TAKE && !w_tick) begin
        r_pend <= r_pend - 1'b1;
      end
    end
  end

  assign o_REF_PEND = r_pend;

endmodule

// File: rtl/u712_chip_ram_arbiter.sv
// Slot-aligned arbiter granting the chip RAM sequencer to Agnus DMA, CPU or refresh.
module u712_chip_ram_arbiter
  import u712_pkg::*;
#(
  parameter int unsigned REF_INTERVAL   = REF_INTERVAL_DEF,
  parameter int unsigned REF_PEND_MAX   = REF_PEND_MAX_DEF,
  parameter int unsigned REF_URGENT     = REF_URGENT_DEF,
  parameter int unsigned CPU_LATE_LIMIT = CPU_LATE_LIMIT_DEF
) (
  input  logic                    i_CLK80,
  input  logic                    i_RESETn,
  u712_chip_ram_arbiter_if.slave  bus
);

  logic               r_c1_s1, r_c1_s2, r_c1_s3;
  logic               r_c3_s1, r_c3_s2;
  logic               r_slot_start;
  logic [PHASE_W-1:0] r_phase;
  arb_state_e         r_state;
  arb_state_e         w_next;
  logic               r_dma_gnt, r_cpu_gnt, r_ref_gnt;
  logic               r_dma_miss;
  logic               w_slot_det;
  logic               w_ref_take;
  logic               w_miss_set;
  logic [PEND_W-1:0]  w_ref_pend;

  // Slot boundary: synced C1 rising while synced C3 is low; C3 high marks a glitch.
  assign w_slot_det = r_c1_s2 && !r_c1_s3 && !r_c3_s2;

  always_ff @(posedge i_CLK80) begin
    if (!i_RESETn) begin
      r_c1_s1      <= 1'b0;
      r_c1_s2      <= 1'b0;
      r_c1_s3      <= 1'b0;
      r_c3_s1      <= 1'b0;
      r_c3_s2      <= 1'b0;
      r_slot_start <= 1'b0;
      r_phase      <= '0;
    end else begin
      r_c1_s1      <= bus.i_C1;
      r_c1_s2      <= r_c1_s1;
      r_c1_s3      <= r_c1_s2;
      r_c3_s1      <= bus.i_C3;
      r_c3_s2      <= r_c3_s1;
      r_slot_start <= w_slot_det;
      if (w_slot_det)       r_phase <= '0;
      else if (r_phase != '1) r_phase <= r_phase + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (r_slot_start) begin
          if (!bus.i_DBR_SYNC)                           w_next = ST_DMA;
          else if (w_ref_pend >= PEND_W'(REF_URGENT))    w_next = ST_REF;
          else if (bus.i_CPU_REQ)                        w_next = ST_CPU;
          else if (w_ref_pend != '0)                     w_next = ST_REF;
        end else if (bus.i_CPU_REQ && bus.i_DBR_SYNC &&
                     (r_phase <= PHASE_W'(CPU_LATE_LIMIT))) begin
          w_next = ST_CPU;
        end
      end
      default: begin
        if (bus.i_CYC_DONE) w_next = ST_IDLE;
      end
    endcase
  end

  assign w_ref_take = (r_state == ST_IDLE) && (w_next == ST_REF);
  assign w_miss_set = r_slot_start && (r_state != ST_IDLE) && !bus.i_DBR_SYNC;

  always_ff @(posedge i_CLK80) begin
    if (!i_RESETn) begin
      r_state    <= ST_IDLE;
      r_dma_gnt  <= 1'b0;
      r_cpu_gnt  <= 1'b0;
      r_ref_gnt  <= 1'b0;
      r_dma_miss <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_dma_gnt  <= (w_next == ST_DMA);
      r_cpu_gnt  <= (w_next == ST_CPU);
      r_ref_gnt  <= (w_next == ST_REF);
      if (w_miss_set) r_dma_miss <= 1'b1;
    end
  end

  u712_refresh_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .REF_PEND_MAX (REF_PEND_MAX)
  ) u_refresh (
    .i_CLK80    (i_CLK80),
    .i_RESETn   (i_RESETn),
    .i_REF_TAKE (w_ref_take),
    .o_REF_PEND (w_ref_pend)
  );

  assign bus.o_DMA_GNT    = r_dma_gnt;
  assign bus.o_CPU_GNT    = r_cpu_gnt;
  assign bus.o_REF_GNT    = r_ref_gnt;
  assign bus.o_SLOT_START = r_slot_start;
  assign bus.o_SLOT_PHASE = r_phase;
  assign bus.o_REF_PEND   = w_ref_pend;
  assign bus.o_DMA_MISS   = r_dma_miss;

endmodule

// File: doc/u712_chip_ram_arbiter.md
Name: u712_chip_ram_arbiter

Overview:
Slot-based arbiter for the shared chip RAM SDRAM on the U712 FPGA. It aligns to the Amiga C1/C3 bus-cycle phases on CLK80 and grants the SDRAM sequencer to one of three requesters per bus slot: Agnus DMA, the CPU, or an internally timed refresh. It sits between the _DBR synchroniser and CPU decode on one side and the chip RAM cycle sequencer on the other.

Parameters:
REF_INTERVAL, 624, CLK80 cycles between refresh ticks (7.8 us at 80 MHz)
REF_PEND_MAX, 7, saturation value of the pending-refresh counter (3-bit)
REF_URGENT, 4, pending count at which refresh outranks CPU
CPU_LATE_LIMIT, 6, last SLOT_PHASE value at which a mid-slot CPU grant may start

Ports:
CLK80  input  1  80 MHz system clock, all logic on rising edge
RESETn  input  1  reset, synchronous, active-low
C1  input  1  Amiga phase clock C1, asynchronous
C3  input  1  Amiga phase clock C3, asynchronous
DBR_SYNC  input  1  Agnus _DBR, already synchronised, low = DMA owns this slot
CPU_REQ  input  1  CPU chip RAM request, level, held until CPU_GNT seen
CYC_DONE  input  1  one-cycle pulse from sequencer, granted cycle complete
DMA_GNT  output  1  DMA owns SDRAM
CPU_GNT  output  1  CPU owns SDRAM
REF_GNT  output  1  refresh owns SDRAM
SLOT_START  output  1  one-cycle pulse at each bus-slot boundary
SLOT_PHASE  output  5  CLK80 count since SLOT_START, saturates at 31
REF_PEND  output  3  outstanding refresh count
DMA_MISS  output  1  sticky: DMA slot arrived while SDRAM busy

Behaviour:
- Reset (RESETn low at clock edge): state IDLE; all GNTs 0, SLOT_START 0, SLOT_PHASE 0, REF_PEND 0, DMA_MISS 0, refresh timer 0, C1/C3 sync flops 0.
- C1 and C3 pass through 2-flop synchronisers. SLOT_START = rising edge of synced C1 with synced C3 low. Latency is 3 CLK80 from the C1 pin edge. A C1 edge with C3 high is ignored as a phase glitch.
- SLOT_PHASE clears to 0 on SLOT_START, then increments and holds at 31.
- States: IDLE, DMA, CPU, REF. Exactly one GNT is high in its matching state; all are low in IDLE. GNTs are registered.
- Slot-start decision in IDLE, evaluated in the SLOT_START cycle, with the grant visible the next cycle. Priority order:
  1. DBR_SYNC=0 -> DMA
  2. REF_PEND>=REF_URGENT -> REF
  3. CPU_REQ -> CPU
  4. REF_PEND>0 -> REF
  5. Otherwise stay IDLE.
- Mid-slot CPU grant: in IDLE with no SLOT_START, CPU_REQ=1, SLOT_PHASE<=CPU_LATE_LIMIT and DBR_SYNC=1 -> CPU. A request after the limit waits for the next slot.
- Grant hold: a grant stays high until CYC_DONE, then returns to IDLE on the next edge. No new grant is issued in the CYC_DONE cycle. CYC_DONE in IDLE is ignored.
- Busy at slot boundary: SLOT_START while not IDLE and DBR_SYNC=0 sets DMA_MISS (sticky until reset). The current grant continues. No pre-emption.
- Refresh timer: counts 0..REF_INTERVAL-1, ticks on wrap.
  - Tick: REF_PEND+1, saturating at REF_PEND_MAX.
  - REF grant (IDLE->REF transition): REF_PEND-1.
  - Tick and REF grant in the same cycle: REF_PEND unchanged.
  - A tick at saturation is dropped.
- Mid-operation reset: all grants drop on the first reset edge, with no wait for CYC_DONE.

Decomposition:
- Shared package u712_pkg: state encoding localparams (IDLE, DMA, CPU, REF), default REF_INTERVAL and REF_URGENT constants.
- One sub-module, u712_refresh_timer: interval counter plus saturating REF_PEND up/down counter. Its inputs are CLK80, RESETn and REF_TAKE; its output is REF_PEND.
- Arbiter FSM, slot detection and synchronisers stay in the top module.

Test Plan:
- C1 rises with C3 low, DBR_SYNC=0 -> SLOT_START 3 cycles after the pin edge, DMA_GNT=1 the next cycle; CYC_DONE at phase 10 -> DMA_GNT=0 at phase 11.
- DBR_SYNC=1, CPU_REQ raised at phase 4 -> CPU_GNT=1 at phase 5. CPU_REQ raised at phase 8 -> CPU_GNT waits until the cycle after the next SLOT_START.
- REF_INTERVAL=16, no CPU/DMA for 80 cycles -> REF_PEND rises to 5 and saturates at 7. At a slot with REF_PEND=4 and CPU_REQ=1 -> REF_GNT wins and REF_PEND=3.
- Timer tick in the same cycle as an IDLE->REF grant with REF_PEND=2 -> REF_PEND stays 2.
- CPU_GNT held with no CYC_DONE across a SLOT_START with DBR_SYNC=0 -> DMA_MISS=1, CPU_GNT stays 1, DMA_GNT stays 0.
- RESETn low while REF_GNT=1 and REF_PEND=5 -> next edge: all GNT=0, REF_PEND=0, SLOT_PHASE=0, DMA_MISS=0.
